// File: rtl/rob_buffer.sv
// Reorder buffer: circular queue of in-flight instructions.
// Allocated in order, filled out of order from the CDB, retired in order.
module rob_buffer #(
    parameter int ROB_DEPTH   = 8,
    parameter int ROB_IDX_LEN = 3,
    parameter int REG_IDX_LEN = 5,
    parameter int XLEN        = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [REG_IDX_LEN-1:0] issue_rd_idx_i,
    output logic [ROB_IDX_LEN-1:0] issue_tail_idx_o,
    input  logic [ROB_IDX_LEN-1:0] issue_rs1_rob_idx_i,
    output logic                   issue_rs1_ready_o,
    output logic [XLEN-1:0]        issue_rs1_value_o,
    input  logic [ROB_IDX_LEN-1:0] issue_rs2_rob_idx_i,
    output logic                   issue_rs2_ready_o,
    output logic [XLEN-1:0]        issue_rs2_value_o,
    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_rob_idx_i,
    input  logic [XLEN-1:0]        cdb_value_i,
    input  logic                   cdb_except_i,
    output logic                   comm_valid_o,
    input  logic                   comm_ready_i,
    output logic [ROB_IDX_LEN-1:0] comm_head_idx_o,
    output logic [REG_IDX_LEN-1:0] comm_rd_idx_o,
    output logic [XLEN-1:0]        comm_value_o,
    output logic                   comm_except_o
);

    localparam logic [ROB_IDX_LEN:0] FULL = (ROB_IDX_LEN+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]   valid_q;
    logic [ROB_DEPTH-1:0]   res_ready_q;
    logic [ROB_DEPTH-1:0]   except_q;
    logic [REG_IDX_LEN-1:0] rd_q    [ROB_DEPTH];
    logic [XLEN-1:0]        value_q [ROB_DEPTH];
    logic [ROB_IDX_LEN-1:0] head_q;
    logic [ROB_IDX_LEN-1:0] tail_q;
    logic [ROB_IDX_LEN:0]   count_q;

    logic alloc;
    logic commit;
    logic cdb_wr;
    logic rs1_hit;
    logic rs2_hit;

    assign issue_ready_o    = (count_q != FULL);
    assign issue_tail_idx_o = tail_q;

    assign alloc  = issue_valid_i && issue_ready_o;
    assign commit = comm_valid_o && comm_ready_i;
    // Allocation owns the tail slot; a stale broadcast to it is dropped.
    assign cdb_wr = cdb_valid_i && valid_q[cdb_rob_idx_i]
                  && !(alloc && (cdb_rob_idx_i == tail_q));

    assign comm_valid_o    = valid_q[head_q] && res_ready_q[head_q];
    assign comm_head_idx_o = head_q;
    assign comm_rd_idx_o   = rd_q[head_q];
    assign comm_value_o    = value_q[head_q];
    assign comm_except_o   = except_q[head_q];

    assign rs1_hit = cdb_valid_i && (cdb_rob_idx_i == issue_rs1_rob_idx_i)
                   && valid_q[issue_rs1_rob_idx_i];
    assign rs2_hit = cdb_valid_i && (cdb_rob_idx_i == issue_rs2_rob_idx_i)
                   && valid_q[issue_rs2_rob_idx_i];

    assign issue_rs1_ready_o = rs1_hit || (valid_q[issue_rs1_rob_idx_i]
                             && res_ready_q[issue_rs1_rob_idx_i]);
    assign issue_rs1_value_o = rs1_hit ? cdb_value_i
                             : value_q[issue_rs1_rob_idx_i];
    assign issue_rs2_ready_o = rs2_hit || (valid_q[issue_rs2_rob_idx_i]
                             && res_ready_q[issue_rs2_rob_idx_i]);
    assign issue_rs2_value_o = rs2_hit ? cdb_value_i
                             : value_q[issue_rs2_rob_idx_i];

    // Entry flags and queue pointers; reset and flush empty the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q     <= '0;
            res_ready_q <= '0;
            except_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            if (alloc) begin
                valid_q[tail_q]     <= 1'b1;
                res_ready_q[tail_q] <= 1'b0;
                except_q[tail_q]    <= 1'b0;
                tail_q              <= tail_q + ROB_IDX_LEN'(1);
            end
            if (cdb_wr) begin
                res_ready_q[cdb_rob_idx_i] <= 1'b1;
                except_q[cdb_rob_idx_i]    <= cdb_except_i;
            end
            if (commit) begin
                valid_q[head_q]     <= 1'b0;
                res_ready_q[head_q] <= 1'b0;
                head_q              <= head_q + ROB_IDX_LEN'(1);
            end
            case ({alloc, commit})
                2'b10:   count_q <= count_q + (ROB_IDX_LEN+1)'(1);
                2'b01:   count_q <= count_q - (ROB_IDX_LEN+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage; contents are meaningless while the entry is invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (alloc) begin
                rd_q[tail_q] <= issue_rd_idx_i;
            end
            if (cdb_wr) begin
                value_q[cdb_rob_idx_i] <= cdb_value_i;
            end
        end
    end

endmodule

// File: tb/tb_rob_buffer.sv
// Directed bench for rob_buffer: a per-cycle vector table
// followed by hand-written flush/reset/allocation-race sequences.
module tb_rob_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  issue_rd_idx_i;
    logic [2:0]  issue_tail_idx_o;
    logic [2:0]  issue_rs1_rob_idx_i;
    logic        issue_rs1_ready_o;
    logic [63:0] issue_rs1_value_o;
    logic [2:0]  issue_rs2_rob_idx_i;
    logic        issue_rs2_ready_o;
    logic [63:0] issue_rs2_value_o;
    logic        cdb_valid_i;
    logic [2:0]  cdb_rob_idx_i;
    logic [63:0] cdb_value_i;
    logic        cdb_except_i;
    logic        comm_valid_o;
    logic        comm_ready_i;
    logic [2:0]  comm_head_idx_o;
    logic [4:0]  comm_rd_idx_o;
    logic [63:0] comm_value_o;
    logic        comm_except_o;

    rob_buffer dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .issue_valid_i       (issue_valid_i),
        .issue_ready_o       (issue_ready_o),
        .issue_rd_idx_i      (issue_rd_idx_i),
        .issue_tail_idx_o    (issue_tail_idx_o),
        .issue_rs1_rob_idx_i (issue_rs1_rob_idx_i),
        .issue_rs1_ready_o   (issue_rs1_ready_o),
        .issue_rs1_value_o   (issue_rs1_value_o),
        .issue_rs2_rob_idx_i (issue_rs2_rob_idx_i),
        .issue_rs2_ready_o   (issue_rs2_ready_o),
        .issue_rs2_value_o   (issue_rs2_value_o),
        .cdb_valid_i         (cdb_valid_i),
        .cdb_rob_idx_i       (cdb_rob_idx_i),
        .cdb_value_i         (cdb_value_i),
        .cdb_except_i        (cdb_except_i),
        .comm_valid_o        (comm_valid_o),
        .comm_ready_i        (comm_ready_i),
        .comm_head_idx_o     (comm_head_idx_o),
        .comm_rd_idx_o       (comm_rd_idx_o),
        .comm_value_o        (comm_value_o),
        .comm_except_o       (comm_except_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [4:0]  rd;
        logic        cv;
        logic [2:0]  cidx;
        logic [63:0] cval;
        logic        cexc;
        logic        cr;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
    } in_t;

    typedef struct {
        logic        ird;
        logic [2:0]  tail;
        logic        cv;
        logic [2:0]  head;
        logic        chk_rd;
        logic [4:0]  rd;
        logic [63:0] val;
        logic        exc;
        logic        r1;
        logic [63:0] v1;
        logic        r2;
        logic [63:0] v2;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;
    int row      = 0;

    function automatic in_t mk_in(
        logic f, logic iv, logic [4:0] rd, logic cv, logic [2:0] cidx,
        logic [63:0] cval, logic cexc, logic cr, logic [2:0] rs1,
        logic [2:0] rs2);
        in_t t;
        t.flush = f;   t.iv = iv;     t.rd = rd;     t.cv = cv;
        t.cidx = cidx; t.cval = cval; t.cexc = cexc; t.cr = cr;
        t.rs1 = rs1;   t.rs2 = rs2;
        return t;
    endfunction

    function automatic exp_t mk_ex(
        logic ird, logic [2:0] tail, logic cv, logic [2:0] head,
        logic chk_rd, logic [4:0] rd, logic [63:0] val, logic exc,
        logic r1, logic [63:0] v1, logic r2, logic [63:0] v2);
        exp_t t;
        t.ird = ird; t.tail = tail; t.cv = cv; t.head = head;
        t.chk_rd = chk_rd; t.rd = rd; t.val = val; t.exc = exc;
        t.r1 = r1; t.v1 = v1; t.r2 = r2; t.v2 = v2;
        return t;
    endfunction

    task automatic idle();
        rst_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0;
        issue_rd_idx_i = '0; cdb_valid_i = 1'b0; cdb_rob_idx_i = '0;
        cdb_value_i = '0; cdb_except_i = 1'b0; comm_ready_i = 1'b0;
        issue_rs1_rob_idx_i = '0; issue_rs2_rob_idx_i = '0;
    endtask

    task automatic apply(input in_t t);
        flush_i = t.flush; issue_valid_i = t.iv; issue_rd_idx_i = t.rd;
        cdb_valid_i = t.cv; cdb_rob_idx_i = t.cidx;
        cdb_value_i = t.cval; cdb_except_i = t.cexc;
        comm_ready_i = t.cr;
        issue_rs1_rob_idx_i = t.rs1; issue_rs2_rob_idx_i = t.rs2;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h",
                     name, row, act, want);
        end
    endtask

    task automatic check_exp(input exp_t e);
        chk("issue_ready", 64'(issue_ready_o), 64'(e.ird));
        chk("tail", 64'(issue_tail_idx_o), 64'(e.tail));
        chk("comm_valid", 64'(comm_valid_o), 64'(e.cv));
        chk("head", 64'(comm_head_idx_o), 64'(e.head));
        if (e.chk_rd) chk("comm_rd", 64'(comm_rd_idx_o), 64'(e.rd));
        if (e.cv) begin
            chk("comm_value", comm_value_o, e.val);
            chk("comm_except", 64'(comm_except_o), 64'(e.exc));
        end
        chk("rs1_ready", 64'(issue_rs1_ready_o), 64'(e.r1));
        if (e.r1) chk("rs1_value", issue_rs1_value_o, e.v1);
        chk("rs2_ready", 64'(issue_rs2_ready_o), 64'(e.r2));
        if (e.r2) chk("rs2_value", issue_rs2_value_o, e.v2);
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        // Fill 8 entries rd=1..8, then a refused 9th issue.
        vecs[0].i = mk_in(0,1,1,0,0,0,0,0,0,0);
        vecs[0].e = mk_ex(1,0,0,0,0,0,0,0,0,0,0,0);
        for (int k = 1; k < 8; k++) begin
            vecs[k].i = mk_in(0,1,5'(k+1),0,0,0,0,0,0,0);
            vecs[k].e = mk_ex(1,3'(k),0,0,1,1,0,0,0,0,0,0);
        end
        vecs[8].i  = mk_in(0,1,9,0,0,0,0,0,0,0);
        vecs[8].e  = mk_ex(0,0,0,0,1,1,0,0,0,0,0,0);
        // Out-of-order CDB writes with bypass to rs1/rs2.
        vecs[9].i  = mk_in(0,0,0,1,2,64'hAA,0,0,2,0);
        vecs[9].e  = mk_ex(0,0,0,0,1,1,0,0,1,64'hAA,0,0);
        vecs[10].i = mk_in(0,0,0,1,0,64'h11,0,0,2,0);
        vecs[10].e = mk_ex(0,0,0,0,1,1,0,0,1,64'hAA,1,64'h11);
        // Full: commit accepted, issue refused; then issue wraps to 0.
        vecs[11].i = mk_in(0,1,9,0,0,0,0,1,0,2);
        vecs[11].e = mk_ex(0,0,1,0,1,1,64'h11,0,1,64'h11,1,64'hAA);
        vecs[12].i = mk_in(0,1,9,0,0,0,0,1,0,1);
        vecs[12].e = mk_ex(1,0,0,1,1,2,0,0,0,0,0,0);
        vecs[13].i = mk_in(0,0,0,1,1,64'h22,1,0,0,1);
        vecs[13].e = mk_ex(0,1,0,1,1,2,0,0,0,0,1,64'h22);
        // Commit stall for 3 cycles, then release.
        for (int k = 14; k < 17; k++) begin
            vecs[k].i = mk_in(0,0,0,0,0,0,0,0,1,0);
            vecs[k].e = mk_ex(0,1,1,1,1,2,64'h22,1,1,64'h22,0,0);
        end
        vecs[17].i = mk_in(0,0,0,0,0,0,0,1,1,0);
        vecs[17].e = mk_ex(0,1,1,1,1,2,64'h22,1,1,64'h22,0,0);
        vecs[18].i = mk_in(0,0,0,0,0,0,0,1,0,0);
        vecs[18].e = mk_ex(1,1,1,2,1,3,64'hAA,0,0,0,0,0);
        // rs1 lookup of idx 3 before and during its CDB write.
        vecs[19].i = mk_in(0,0,0,0,0,0,0,1,3,0);
        vecs[19].e = mk_ex(1,1,0,3,1,4,0,0,0,0,0,0);
        vecs[20].i = mk_in(0,0,0,1,3,64'h55,0,0,3,0);
        vecs[20].e = mk_ex(1,1,0,3,1,4,0,0,1,64'h55,0,0);
        vecs[21].i = mk_in(0,0,0,0,0,0,0,0,3,0);
        vecs[21].e = mk_ex(1,1,1,3,1,4,64'h55,0,1,64'h55,0,0);
        vecs[22].i = mk_in(0,0,0,0,0,0,0,1,3,0);
        vecs[22].e = mk_ex(1,1,1,3,1,4,64'h55,0,1,64'h55,0,0);
        // Flush with 5 live entries, alongside issue and CDB.
        vecs[23].i = mk_in(1,1,20,1,4,64'h77,0,0,4,0);
        vecs[23].e = mk_ex(1,1,0,4,1,5,0,0,1,64'h77,0,0);
        vecs[24].i = mk_in(0,0,0,0,0,0,0,0,4,0);
        vecs[24].e = mk_ex(1,0,0,0,0,0,0,0,0,0,0,0);

        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int n = 0; n < NV; n++) begin
            row = n;
            apply(vecs[n].i);
            #1;
            check_exp(vecs[n].e);
            step();
        end

        // After flush the count must be 0: eight more fit, not three.
        row = 100;
        idle();
        for (int k = 0; k < 8; k++) begin
            issue_valid_i = 1'b1;
            issue_rd_idx_i = 5'(k + 1);
            #1;
            chk("refill_ready", 64'(issue_ready_o), 64'd1);
            chk("refill_tail", 64'(issue_tail_idx_o), 64'(k));
            step();
        end
        #1;
        chk("refill_full", 64'(issue_ready_o), 64'd0);
        idle();

        // Reset mid-sequence, with issue, CDB and commit pending.
        row = 101;
        cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd2; cdb_value_i = 64'h33;
        step();
        rst_i = 1'b1; issue_valid_i = 1'b1; issue_rd_idx_i = 5'd9;
        cdb_rob_idx_i = 3'd5; cdb_value_i = 64'h44; comm_ready_i = 1'b1;
        step();
        idle();
        issue_rs1_rob_idx_i = 3'd2;
        #1;
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_tail", 64'(issue_tail_idx_o), 64'd0);
        chk("rst_head", 64'(comm_head_idx_o), 64'd0);
        chk("rst_comm_valid", 64'(comm_valid_o), 64'd0);
        chk("rst_rs1_ready", 64'(issue_rs1_ready_o), 64'd0);

        // CDB aimed at the slot being allocated is dropped.
        row = 102;
        issue_valid_i = 1'b1; issue_rd_idx_i = 5'd7;
        cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd0; cdb_value_i = 64'h99;
        step();
        idle();
        #1;
        chk("race_comm_valid", 64'(comm_valid_o), 64'd0);
        chk("race_rs1_ready", 64'(issue_rs1_ready_o), 64'd0);
        chk("race_rd", 64'(comm_rd_idx_o), 64'd7);
        chk("race_tail", 64'(issue_tail_idx_o), 64'd1);
        cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd0; cdb_value_i = 64'h99;
        step();
        idle();
        #1;
        chk("late_comm_valid", 64'(comm_valid_o), 64'd1);
        chk("late_value", comm_value_o, 64'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
